cpu_bus_bridge: RTL and testbench

CPU_BUS_BRIDGE -- requirements
Module: cpu_bus_bridge

---
 rtl/cpu_bus_pkg.sv | 45 ++++
 rtl/cpu_bus_bridge_phase.sv | 22 ++
 rtl/cpu_bus_bridge.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cpu_bus_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU bus bridge: FSM state encoding, SIZ/TT codes and
// byte-lane mask encodings.
package cpu_bus_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    REQ       = 4'd1,
    RD_TURN   = 4'd2,
    RD_BEAT   = 4'd3,
    RD_HOLD   = 4'd4,
    WR_TA     = 4'd5,
    WR_CAP    = 4'd6,
    WR_HOLD   = 4'd7,
    IRQ_WAIT  = 4'd8,
    IRQ_TURN  = 4'd9,
    IRQ_DRIVE = 4'd10,
    IRQ_END   = 4'd11,
    ERR       = 4'd12
  } state_t;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam logic [1:0] TT_NORM0 = 2'b00;
  localparam logic [1:0] TT_NORM1 = 2'b01;
  localparam logic [1:0] TT_ALT   = 2'b10;
  localparam logic [1:0] TT_IACK  = 2'b11;

  localparam logic [3:0] MASK_ALL = 4'b1111;
  localparam logic [3:0] MASK_HI  = 4'b1100;
  localparam logic [3:0] MASK_LO  = 4'b0011;
  localparam logic [3:0] MASK_B0  = 4'b1000;

  // Lane 0 is the most significant byte (big-endian bus).
  function automatic logic [3:0] siz_mask(input logic [1:0] siz, input logic [1:0] a);
    case (siz)
      SIZ_BYTE: siz_mask = MASK_B0 >> a;
      SIZ_WORD: siz_mask = a[1] ? MASK_LO : MASK_HI;
      default:  siz_mask = MASK_ALL;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_bridge_phase.sv
// bus_phase_gen: tracks the position of clk_i within the slower bus clock.
// The bus rising edge lands on phase 2, so phase 0/1 fall mid bus-clock.
module bus_phase_gen #(
  parameter int CLK_DIV = 3,
  parameter int PH_W    = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            bclk_rise,
  output logic [PH_W-1:0] phase
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i)                 phase <= '0;
    else if (bclk_rise)        phase <= PH_W'(2);
    else if (phase >= PH_LAST) phase <= '0;
    else                       phase <= phase + 1'b1;
  end

endmodule

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: turns CPU bus cycles (TS/TA) into req/read/write handshakes.
// Optional bus-error timeout is built when CPU_BUS_TIMEOUT_EN is defined.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int          CLK_DIV      = 3,
  parameter int          LINE_BEATS   = 4,
  parameter int          BOOT_FETCHES = 2,
  parameter logic [15:0] ROM_OFF      = 16'h4000,
  parameter int          TIMEOUT      = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              bclk_rise,
  input  logic [31:0]                       ad_i,
  output logic [31:0]                       ad_o,
  output logic                              ad_oe,
  output logic                              cpu_dir,
  output logic                              cpu_oe,
  input  logic                              cpu_ts_n,
  input  logic [1:0]                        cpu_tt,
  input  logic [1:0]                        cpu_siz,
  input  logic                              cpu_rw,
  output logic                              cpu_ta_n,
  output logic                              cpu_tea_n,
  output logic                              req_valid,
  input  logic                              req_ready,
  output logic [$clog2(LINE_BEATS+1)-1:0]   req_len,
  output logic [3:0]                        req_mask,
  output logic [31:0]                       req_addr,
  output logic                              req_we,
  output logic                              write_valid,
  output logic [31:0]                       write_data,
  input  logic                              read_valid,
  input  logic [31:0]                       read_data,
  output logic                              read_ack,
  input  logic                              irq_req,
  input  logic [7:0]                        irq_vec,
  output logic                              irq_ack,
  output logic                              busy,
  output state_t                            dbg_state
);

  localparam int               LEN_W    = $clog2(LINE_BEATS + 1);
  localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LINE_LEN = LEN_W'(LINE_BEATS);
  localparam logic [3:0]       BOOT_N   = 4'(BOOT_FETCHES);
  localparam logic [2:0]       PH0      = 3'd0;
  localparam logic [2:0]       PH1      = 3'd1;

  logic [2:0]       phase;
  state_t           state_q, state_d;
  logic [3:0]       boot_q, boot_d;
  logic [LEN_W-1:0] beat_q, beat_d, req_len_d;
  logic [31:0]      req_addr_d, write_data_d, ad_o_d;
  logic [3:0]       req_mask_d;
  logic             req_valid_d, req_we_d, write_valid_d, read_ack_d, irq_ack_d;
  logic             ad_oe_d, dir_d, oe_d, ta_n_d;

  bus_phase_gen #(.CLK_DIV(CLK_DIV), .PH_W(3)) u_phase (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bclk_rise (bclk_rise),
    .phase     (phase)
  );

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int            TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  logic [TO_W-1:0] to_q, to_d;
  logic            tea_n_q, tea_n_d;

  assign cpu_tea_n = tea_n_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_q    <= '0;
      tea_n_q <= 1'b1;
    end else begin
      to_q    <= to_d;
      tea_n_q <= tea_n_d;
    end
  end
`else
  assign cpu_tea_n = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    boot_d        = boot_q;
    beat_d        = beat_q;
    req_valid_d   = req_valid;
    req_len_d     = req_len;
    req_mask_d    = req_mask;
    req_addr_d    = req_addr;
    req_we_d      = req_we;
    write_valid_d = 1'b0;
    write_data_d  = write_data;
    read_ack_d    = 1'b0;
    irq_ack_d     = irq_ack;
    ad_o_d        = ad_o;
    ad_oe_d       = ad_oe;
    dir_d         = cpu_dir;
    oe_d          = cpu_oe;
    ta_n_d        = cpu_ta_n;
`ifdef CPU_BUS_TIMEOUT_EN
    tea_n_d       = tea_n_q;
    to_d          = '0;
`endif
    case (state_q)
      IDLE: if (phase == PH0 && !cpu_ts_n) begin
        if (cpu_tt == TT_IACK) begin
          irq_ack_d = 1'b1;
          oe_d      = 1'b1;
          state_d   = IRQ_WAIT;
        end else if (cpu_tt != TT_ALT) begin
          req_valid_d = 1'b1;
          req_we_d    = ~cpu_rw;
          req_mask_d  = siz_mask(cpu_siz, ad_i[1:0]);
          req_len_d   = (cpu_siz == SIZ_LINE) ? LINE_LEN : ONE_LEN;
          beat_d      = req_len_d;
          // Early fetches after reset are steered into the boot ROM window.
          req_addr_d  = (boot_q < BOOT_N) ? {ROM_OFF, ad_i[15:0]} : ad_i;
          oe_d        = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: if (req_ready) begin
        req_valid_d = 1'b0;
        if (boot_q < BOOT_N) boot_d = boot_q + 4'd1;
        state_d = req_we ? WR_TA : RD_TURN;
      end
      RD_TURN: if (phase == PH1) begin
        dir_d   = 1'b0;
        state_d = RD_BEAT;
      end
      RD_BEAT: if (phase == PH1 && read_valid) begin
        ad_o_d     = read_data;
        read_ack_d = 1'b1;
        ad_oe_d    = 1'b1;
        ta_n_d     = 1'b0;
        state_d    = RD_HOLD;
      end
      RD_HOLD: if (phase == PH1) begin
        ta_n_d = 1'b1;
        if (beat_q > ONE_LEN) begin
          beat_d  = beat_q - ONE_LEN;
          state_d = RD_BEAT;
        end else begin
          dir_d   = 1'b1;
          ad_oe_d = 1'b0;
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      WR_TA: if (phase == PH1) begin
        ta_n_d  = 1'b0;
        state_d = WR_CAP;
      end
      WR_CAP: if (phase == PH0) begin
        write_valid_d = 1'b1;
        write_data_d  = ad_i;
        state_d       = WR_HOLD;
      end
      WR_HOLD: if (phase == PH1) begin
        if (beat_q > ONE_LEN) begin
          beat_d  = beat_q - ONE_LEN;
          state_d = WR_CAP;
        end else begin
          ta_n_d  = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      IRQ_WAIT: if (irq_req) begin
        irq_ack_d = 1'b0;
        ad_o_d    = {24'd0, irq_vec};
        state_d   = IRQ_TURN;
      end
      IRQ_TURN: begin
        dir_d   = 1'b0;
        state_d = IRQ_DRIVE;
      end
      IRQ_DRIVE: if (phase == PH1) begin
        ad_oe_d = 1'b1;
        ta_n_d  = 1'b0;
        state_d = IRQ_END;
      end
      IRQ_END: if (phase == PH1) begin
        ta_n_d  = 1'b1;
        ad_oe_d = 1'b0;
        dir_d   = 1'b1;
        oe_d    = 1'b0;
        state_d = IDLE;
      end
`ifdef CPU_BUS_TIMEOUT_EN
      // TEA is asserted for exactly one bus clock, phase 1 to phase 1.
      ERR: if (phase == PH1) begin
        if (tea_n_q) begin
          tea_n_d = 1'b0;
        end else begin
          tea_n_d = 1'b1;
          ta_n_d  = 1'b1;
          dir_d   = 1'b1;
          ad_oe_d = 1'b0;
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef CPU_BUS_TIMEOUT_EN
    if (state_q == REQ || state_q == RD_BEAT) begin
      to_d = to_q + 1'b1;
      if (state_d == state_q && to_d == TO_LIM) begin
        req_valid_d = 1'b0;
        to_d        = '0;
        state_d     = ERR;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      boot_q      <= '0;
      beat_q      <= '0;
      req_valid   <= 1'b0;
      req_len     <= '0;
      req_mask    <= '0;
      req_addr    <= '0;
      req_we      <= 1'b0;
      write_valid <= 1'b0;
      write_data  <= '0;
      read_ack    <= 1'b0;
      irq_ack     <= 1'b0;
      ad_o        <= '0;
      ad_oe       <= 1'b0;
      cpu_dir     <= 1'b1;
      cpu_oe      <= 1'b0;
      cpu_ta_n    <= 1'b1;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      beat_q      <= beat_d;
      req_valid   <= req_valid_d;
      req_len     <= req_len_d;
      req_mask    <= req_mask_d;
      req_addr    <= req_addr_d;
      req_we      <= req_we_d;
      write_valid <= write_valid_d;
      write_data  <= write_data_d;
      read_ack    <= read_ack_d;
      irq_ack     <= irq_ack_d;
      ad_o        <= ad_o_d;
      ad_oe       <= ad_oe_d;
      cpu_dir     <= dir_d;
      cpu_oe      <= oe_d;
      cpu_ta_n    <= ta_n_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge: CLK_DIV=3, LINE_BEATS=4, BOOT_FETCHES=2,
// TIMEOUT=16. Inputs change on negedge; outputs are sampled on negedge.
module tb_cpu_bus_bridge;
  import cpu_bus_pkg::*;

  localparam int SEL_BUSY = 0, SEL_TA = 1, SEL_WV = 2, SEL_IRQ_ACK = 3, SEL_TEA = 4;

  logic        clk = 1'b0;
  logic        rst_i, bclk_rise;
  logic [31:0] ad_i, ad_o, req_addr, write_data, read_data;
  logic        ad_oe, cpu_dir, cpu_oe, cpu_ts_n, cpu_rw, cpu_ta_n, cpu_tea_n;
  logic [1:0]  cpu_tt, cpu_siz;
  logic        req_valid, req_ready, req_we, write_valid, read_valid, read_ack;
  logic [2:0]  req_len;
  logic [3:0]  req_mask;
  logic        irq_req, irq_ack, busy;
  logic [7:0]  irq_vec;
  state_t      dbg_state;

  int n_checks = 0, n_errors = 0;
  int ta_low_cnt = 0, ra_cnt = 0, wv_cnt = 0, overlap_cnt = 0;
  logic [31:0] wd_log [8];
  logic [31:0] exp_q[$];
  logic [31:0] w [4];
  int ta_b, wv_b, ra_b, cyc;

  cpu_bus_bridge #(
    .CLK_DIV(3), .LINE_BEATS(4), .BOOT_FETCHES(2), .ROM_OFF(16'h4000), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .bclk_rise(bclk_rise),
    .ad_i(ad_i), .ad_o(ad_o), .ad_oe(ad_oe), .cpu_dir(cpu_dir), .cpu_oe(cpu_oe),
    .cpu_ts_n(cpu_ts_n), .cpu_tt(cpu_tt), .cpu_siz(cpu_siz), .cpu_rw(cpu_rw),
    .cpu_ta_n(cpu_ta_n), .cpu_tea_n(cpu_tea_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .req_mask(req_mask), .req_addr(req_addr), .req_we(req_we),
    .write_valid(write_valid), .write_data(write_data),
    .read_valid(read_valid), .read_data(read_data), .read_ack(read_ack),
    .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock / bus-clock generation
  always #5 clk = ~clk;

  initial begin
    bclk_rise = 1'b0;
    forever begin
      repeat (2) @(negedge clk);
      bclk_rise = 1'b1;
      @(negedge clk);
      bclk_rise = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Bus monitor: TA-low cycles, strobe counts and a log of written words
  always @(negedge clk) begin
    if (!rst_i) begin
      if (!cpu_ta_n) ta_low_cnt++;
      if (read_ack) ra_cnt++;
      if (read_ack && write_valid) overlap_cnt++;
      if (write_valid) begin
        wd_log[wv_cnt % 8] = write_data;
        wv_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      SEL_BUSY:    return busy;
      SEL_TA:      return cpu_ta_n;
      SEL_WV:      return write_valid;
      SEL_IRQ_ACK: return irq_ack;
      default:     return cpu_tea_n;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int sel, input logic val, input int limit);
    logic cur;
    cur = ~val;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cur = sig_sel(sel);
      if (cur == val) break;
    end
    check(tag, 32'(cur), 32'(val));
  endtask

  // Driver tasks
  task automatic start_xfer(input logic [1:0] tt, input logic [1:0] siz,
                            input logic rw, input logic [31:0] addr);
    @(negedge clk);
    cpu_tt = tt; cpu_siz = siz; cpu_rw = rw; ad_i = addr; cpu_ts_n = 1'b0;
    wait_sig("ts_accept", SEL_BUSY, 1'b1, 20);
    cpu_ts_n = 1'b1;
  endtask

  task automatic handshake();
    repeat (3) @(negedge clk);
    check("req_hold", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("req_drop", 32'(req_valid), 32'd0);
  endtask

  task automatic read_beat(input logic [31:0] data);
    wait_sig("rd_ta_idle", SEL_TA, 1'b1, 30);
    read_data = data; read_valid = 1'b1;
    wait_sig("rd_ta_low", SEL_TA, 1'b0, 40);
    check("rd_ad_o", ad_o, data);
    check("rd_ack", 32'(read_ack), 32'd1);
    check("rd_ad_oe", 32'(ad_oe), 32'd1);
    check("rd_dir", 32'(cpu_dir), 32'd0);
    read_valid = 1'b0;
  endtask

  task automatic finish_idle(input int base, input int ta_exp);
    wait_sig("idle", SEL_BUSY, 1'b0, 80);
    check("idle_state", 32'(dbg_state), 32'(IDLE));
    check("idle_dir", 32'(cpu_dir), 32'd1);
    check("idle_cpu_oe", 32'(cpu_oe), 32'd0);
    check("idle_ad_oe", 32'(ad_oe), 32'd0);
    check("idle_ta", 32'(cpu_ta_n), 32'd1);
    check("ta_cycles", 32'(ta_low_cnt - base), 32'(ta_exp));
  endtask

  task automatic check_req(input logic [31:0] addr, input logic [3:0] mask,
                           input logic [2:0] len, input logic we);
    check("req_addr", req_addr, addr);
    check("req_mask", 32'(req_mask), 32'(mask));
    check("req_len", 32'(req_len), 32'(len));
    check("req_we", 32'(req_we), 32'(we));
  endtask

  initial begin
    rst_i = 1'b1; ad_i = '0; cpu_ts_n = 1'b1; cpu_tt = 2'b00; cpu_siz = 2'b00; cpu_rw = 1'b1;
    req_ready = 1'b0; read_valid = 1'b0; read_data = '0; irq_req = 1'b0; irq_vec = '0;
    repeat (4) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dir", 32'(cpu_dir), 32'd1);
    check("rst_cpu_oe", 32'(cpu_oe), 32'd0);
    check("rst_ad_oe", 32'(ad_oe), 32'd0);
    check("rst_ta", 32'(cpu_ta_n), 32'd1);
    check("rst_tea", 32'(cpu_tea_n), 32'd1);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_irq_ack", 32'(irq_ack), 32'd0);
    rst_i = 1'b0;

    // TT=10 must not start a cycle
    @(negedge clk);
    cpu_tt = TT_ALT; cpu_ts_n = 1'b0;
    repeat (9) @(negedge clk);
    check("alt_tt_busy", 32'(busy), 32'd0);
    check("alt_tt_req", 32'(req_valid), 32'd0);
    cpu_ts_n = 1'b1;

    // Long read, first boot fetch
    ta_b = ta_low_cnt; ra_b = ra_cnt;
    start_xfer(TT_NORM0, SIZ_LONG, 1'b1, 32'h8000_1234);
    check_req(32'h4000_1234, 4'b1111, 3'd1, 1'b0);
    handshake();
    read_beat(32'hCAFE_0001);
    finish_idle(ta_b, 3);
    check("long_rd_acks", 32'(ra_cnt - ra_b), 32'd1);

    // Line write, second boot fetch
    ta_b = ta_low_cnt; wv_b = wv_cnt;
    start_xfer(TT_NORM1, SIZ_LINE, 1'b0, 32'h9000_0010);
    check_req(32'h4000_0010, 4'b1111, 3'd4, 1'b1);
    handshake();
    w[0] = 32'hA0A0_0001; w[1] = 32'hB0B0_0002; w[2] = 32'hC0C0_0003; w[3] = 32'hD0D0_0004;
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
    ad_i = w[0];
    for (int i = 1; i < 4; i++) begin
      wait_sig("wr_strobe", SEL_WV, 1'b1, 40);
      ad_i = w[i];
    end
    wait_sig("wr_strobe", SEL_WV, 1'b1, 40);
    finish_idle(ta_b, 12);
    check("line_wr_count", 32'(wv_cnt - wv_b), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("line_wr_data%0d", i), wd_log[(wv_b + i) % 8], exp_q.pop_front());

    // Byte read, third access: address passes through
    ta_b = ta_low_cnt;
    start_xfer(TT_NORM0, SIZ_BYTE, 1'b1, 32'h1234_5676);
    check_req(32'h1234_5676, 4'b0010, 3'd1, 1'b0);
    handshake();
    read_beat(32'h0000_00AB);
    finish_idle(ta_b, 3);

    // Word write at addr[1]=1
    ta_b = ta_low_cnt; wv_b = wv_cnt;
    start_xfer(TT_NORM0, SIZ_WORD, 1'b0, 32'h0000_1002);
    check_req(32'h0000_1002, 4'b0011, 3'd1, 1'b1);
    handshake();
    exp_q.push_back(32'h5555_AAAA);
    ad_i = 32'h5555_AAAA;
    wait_sig("word_wr_strobe", SEL_WV, 1'b1, 40);
    finish_idle(ta_b, 3);
    check("word_wr_count", 32'(wv_cnt - wv_b), 32'd1);
    check("word_wr_data", wd_log[wv_b % 8], exp_q.pop_front());

    // Interrupt acknowledge
    ta_b = ta_low_cnt;
    start_xfer(TT_IACK, SIZ_LONG, 1'b1, 32'hFFFF_FFF0);
    check("iack_ack_set", 32'(irq_ack), 32'd1);
    repeat (5) @(negedge clk);
    check("iack_wait_ack", 32'(irq_ack), 32'd1);
    check("iack_wait_state", 32'(dbg_state), 32'(IRQ_WAIT));
    irq_vec = 8'h4A; irq_req = 1'b1;
    wait_sig("iack_ack_clear", SEL_IRQ_ACK, 1'b0, 10);
    irq_req = 1'b0;
    wait_sig("iack_ta_low", SEL_TA, 1'b0, 20);
    check("iack_vector", ad_o, 32'h0000_004A);
    check("iack_ad_oe", 32'(ad_oe), 32'd1);
    check("iack_dir", 32'(cpu_dir), 32'd0);
    finish_idle(ta_b, 3);

    // Reset pulsed during beat 2 of a line read
    ra_b = ra_cnt;
    start_xfer(TT_NORM0, SIZ_LINE, 1'b1, 32'h2000_0000);
    check_req(32'h2000_0000, 4'b1111, 3'd4, 1'b0);
    handshake();
    read_beat(32'h1111_0001);
    read_beat(32'h1111_0002);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ta", 32'(cpu_ta_n), 32'd1);
    check("mid_rst_ad_oe", 32'(ad_oe), 32'd0);
    check("mid_rst_dir", 32'(cpu_dir), 32'd1);
    check("mid_rst_cpu_oe", 32'(cpu_oe), 32'd0);
    check("mid_rst_read_ack", 32'(read_ack), 32'd0);
    rst_i = 1'b0;
    ra_b = ra_cnt; wv_b = wv_cnt;
    read_valid = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_no_ack", 32'(ra_cnt - ra_b), 32'd0);
    check("post_rst_no_wr", 32'(wv_cnt - wv_b), 32'd0);
    check("post_rst_idle", 32'(busy), 32'd0);
    read_valid = 1'b0;
    ta_b = ta_low_cnt;
    start_xfer(TT_NORM0, SIZ_LONG, 1'b1, 32'h8000_0004);
    check_req(32'h4000_0004, 4'b1111, 3'd1, 1'b0);
    handshake();
    read_beat(32'h2222_0004);
    finish_idle(ta_b, 3);

`ifdef CPU_BUS_TIMEOUT_EN
    // Timeout with req_ready held low
    start_xfer(TT_NORM0, SIZ_LONG, 1'b1, 32'h3000_0000);
    cyc = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!req_valid) break;
      cyc++;
    end
    check("to_req_cycles", 32'(cyc), 32'd16);
    wait_sig("to_tea_low", SEL_TEA, 1'b0, 20);
    cyc = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_tea_n) break;
      cyc++;
    end
    check("to_tea_cycles", 32'(cyc), 32'd3);
    wait_sig("to_idle", SEL_BUSY, 1'b0, 20);
    check("to_dir", 32'(cpu_dir), 32'd1);
`else
    check("tea_tied_high", 32'(cpu_tea_n), 32'd1);
`endif

    check("no_rdack_wv_overlap", 32'(overlap_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
